// File: rtl/goertzel_multibin.sv
// Multi-bin Goertzel tone analyser: one time-shared MAC updates BINS bins per accepted sample,
// per-bin power is streamed out every BLOCK_N samples. Optional saturation: GOERTZEL_SAT_EN.
module goertzel_multibin #(
    parameter int  SAMPLE_W    = 16,
    parameter int  BINS        = 4,
    parameter int  BLOCK_N     = 1000,
    parameter int  COEF_W      = 18,
    parameter int  ACC_W       = 40,
    parameter int  POWER_SHIFT = 16,
    parameter int  POWER_W     = 64,
    localparam int AW          = (BINS > 1) ? $clog2(BINS) : 1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       coef_we,
    input  logic [AW-1:0]              coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample,
    output logic                       power_valid,
    input  logic                       power_ready,
    output logic [AW-1:0]              power_bin,
    output logic [POWER_W-1:0]         power,
    output logic                       power_last,
    output logic                       sample_overrun,
    output logic                       result_overrun
`ifdef GOERTZEL_SAT_EN
    ,
    output logic                       sat_flag
`endif
);
    localparam int CW = $clog2(BLOCK_N);
    localparam int PW = COEF_W + ACC_W;
    localparam int DW = 2 * ACC_W;
    localparam int SH = COEF_W - 2;

    typedef enum logic       {U_IDLE, U_UPDATE} uState_t;
    typedef enum logic [1:0] {D_IDLE, D_CALC1, D_CALC2, D_PRESENT} dState_t;

    uState_t r_uState, w_uNext;
    dState_t r_dState, w_dNext;

    logic signed [COEF_W-1:0]   r_coef [BINS];
    logic signed [ACC_W-1:0]    r_s1   [BINS];
    logic signed [ACC_W-1:0]    r_s2   [BINS];
    logic signed [ACC_W-1:0]    r_sh1  [BINS];
    logic signed [ACC_W-1:0]    r_sh2  [BINS];
    logic signed [SAMPLE_W-1:0] r_x;
    logic [AW-1:0]              r_k;
    logic [AW-1:0]              r_dk;
    logic [CW-1:0]              r_cnt;
    logic signed [DW-1:0]       r_sq;
    logic signed [DW-1:0]       r_cross;
    logic [POWER_W-1:0]         r_power;
    logic [AW-1:0]              r_bin;
    logic                       r_last;
    logic                       r_sOvr;
    logic                       r_rOvr;

    logic signed [COEF_W-1:0] w_coefU;
    logic signed [ACC_W-1:0]  w_s1U;
    logic signed [ACC_W-1:0]  w_s2U;
    logic signed [ACC_W-1:0]  w_xExt;
    logic signed [PW-1:0]     w_prodU;
    logic signed [ACC_W-1:0]  w_prodTr;
    logic signed [ACC_W-1:0]  w_s0;
    logic                     w_lastBin;
    logic                     w_blockEnd;

    assign w_coefU    = r_coef[r_k];
    assign w_s1U      = r_s1[r_k];
    assign w_s2U      = r_s2[r_k];
    assign w_xExt     = ACC_W'(r_x);
    assign w_prodU    = w_coefU * w_s1U;
    assign w_prodTr   = ACC_W'(w_prodU >>> SH);
    assign w_lastBin  = (r_uState == U_UPDATE) && (r_k == AW'(BINS - 1));
    assign w_blockEnd = w_lastBin && (r_cnt == CW'(BLOCK_N - 1));

`ifdef GOERTZEL_SAT_EN
    localparam int WW = PW + 2;
    localparam logic signed [WW-1:0] MAXV = {{(WW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [WW-1:0] MINV = {{(WW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    logic signed [WW-1:0] w_sumWide;
    logic                 w_satHit;
    logic                 r_satL [BINS];
    logic                 r_satS [BINS];
    logic                 r_satOut;

    assign w_sumWide = WW'(w_xExt) + WW'(w_prodU >>> SH) - WW'(w_s2U);

    always_comb begin
        w_satHit = 1'b0;
        w_s0     = ACC_W'(w_sumWide);
        if (w_sumWide > MAXV) begin
            w_satHit = 1'b1;
            w_s0     = {1'b0, {(ACC_W-1){1'b1}}};
        end else if (w_sumWide < MINV) begin
            w_satHit = 1'b1;
            w_s0     = {1'b1, {(ACC_W-1){1'b0}}};
        end
    end

    // Per-bin saturation flags follow the same live/snapshot lifecycle as s1/s2.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_satOut <= 1'b0;
            for (int i = 0; i < BINS; i++) begin
                r_satL[i] <= 1'b0;
                r_satS[i] <= 1'b0;
            end
        end else begin
            if (r_uState == U_UPDATE) begin
                if (w_blockEnd) begin
                    for (int i = 0; i < BINS; i++) r_satL[i] <= 1'b0;
                    if (r_dState == D_IDLE) begin
                        for (int i = 0; i < BINS; i++) r_satS[i] <= r_satL[i];
                        r_satS[r_k] <= r_satL[r_k] | w_satHit;
                    end
                end else begin
                    r_satL[r_k] <= r_satL[r_k] | w_satHit;
                end
            end
            if (r_dState == D_CALC2) r_satOut <= r_satS[r_dk];
        end
    end

    assign sat_flag = power_valid & r_satOut;
`else
    assign w_s0 = w_xExt + w_prodTr - w_s2U;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BINS; i++) r_coef[i] <= '0;
        end else if (coef_we) begin
            r_coef[coef_addr] <= coef_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_uState <= U_IDLE;
            r_dState <= D_IDLE;
        end else begin
            r_uState <= w_uNext;
            r_dState <= w_dNext;
        end
    end

    always_comb begin
        w_uNext = r_uState;
        case (r_uState)
            U_IDLE:   if (sample_valid) w_uNext = U_UPDATE;
            U_UPDATE: if (w_lastBin) w_uNext = U_IDLE;
            default:  w_uNext = U_IDLE;
        endcase
    end

    // At block end the snapshot must include the bin being updated in this very cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_x    <= '0;
            r_k    <= '0;
            r_cnt  <= '0;
            r_sOvr <= 1'b0;
            r_rOvr <= 1'b0;
            for (int i = 0; i < BINS; i++) begin
                r_s1[i]  <= '0;
                r_s2[i]  <= '0;
                r_sh1[i] <= '0;
                r_sh2[i] <= '0;
            end
        end else begin
            if (r_uState == U_IDLE && sample_valid) begin
                r_x <= sample;
                r_k <= '0;
            end
            if (r_uState == U_UPDATE) begin
                if (sample_valid) r_sOvr <= 1'b1;
                r_k <= r_k + 1'b1;
                if (w_blockEnd) begin
                    r_cnt <= '0;
                    for (int i = 0; i < BINS; i++) begin
                        r_s1[i] <= '0;
                        r_s2[i] <= '0;
                    end
                    if (r_dState == D_IDLE) begin
                        for (int i = 0; i < BINS; i++) begin
                            r_sh1[i] <= r_s1[i];
                            r_sh2[i] <= r_s2[i];
                        end
                        r_sh1[r_k] <= w_s0;
                        r_sh2[r_k] <= w_s1U;
                    end else begin
                        r_rOvr <= 1'b1;
                    end
                end else begin
                    r_s1[r_k] <= w_s0;
                    r_s2[r_k] <= w_s1U;
                    if (w_lastBin) r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    logic signed [COEF_W-1:0] w_coefD;
    logic signed [ACC_W-1:0]  w_s1D;
    logic signed [ACC_W-1:0]  w_s2D;
    logic signed [PW-1:0]     w_csU;
    logic signed [DW-1:0]     w_cs;
    logic signed [DW-1:0]     w_s1W;
    logic signed [DW-1:0]     w_s2W;
    logic signed [DW-1:0]     w_sqNext;
    logic signed [DW-1:0]     w_crossNext;
    logic signed [DW-1:0]     w_p;
    logic [DW-1:0]            w_pShift;

    assign w_coefD     = r_coef[r_dk];
    assign w_s1D       = r_sh1[r_dk];
    assign w_s2D       = r_sh2[r_dk];
    assign w_csU       = w_coefD * w_s1D;
    assign w_cs        = DW'(w_csU >>> SH);
    assign w_s1W       = DW'(w_s1D);
    assign w_s2W       = DW'(w_s2D);
    assign w_sqNext    = w_s1W * w_s1W + w_s2W * w_s2W;
    assign w_crossNext = w_cs * w_s2W;
    assign w_p         = r_sq - r_cross;
    assign w_pShift    = w_p[DW-1] ? '0 : ($unsigned(w_p) >> POWER_SHIFT);

    always_comb begin
        w_dNext = r_dState;
        case (r_dState)
            D_IDLE:    if (w_blockEnd) w_dNext = D_CALC1;
            D_CALC1:   w_dNext = D_CALC2;
            D_CALC2:   w_dNext = D_PRESENT;
            D_PRESENT: if (power_ready) w_dNext = (r_dk == AW'(BINS - 1)) ? D_IDLE : D_CALC1;
            default:   w_dNext = D_IDLE;
        endcase
    end

    // Squares and cross term are registered first, then combined and clamped in the second cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dk    <= '0;
            r_sq    <= '0;
            r_cross <= '0;
            r_power <= '0;
            r_bin   <= '0;
            r_last  <= 1'b0;
        end else begin
            case (r_dState)
                D_IDLE:    r_dk <= '0;
                D_CALC1: begin
                    r_sq    <= w_sqNext;
                    r_cross <= w_crossNext;
                end
                D_CALC2: begin
                    r_power <= POWER_W'(w_pShift);
                    r_bin   <= r_dk;
                    r_last  <= (r_dk == AW'(BINS - 1));
                end
                D_PRESENT: if (power_ready) r_dk <= r_dk + 1'b1;
                default: ;
            endcase
        end
    end

    assign power_valid    = (r_dState == D_PRESENT);
    assign power          = r_power;
    assign power_bin      = r_bin;
    assign power_last     = r_last;
    assign sample_overrun = r_sOvr;
    assign result_overrun = r_rOvr;

endmodule

// File: tb/tb_goertzel_multibin.sv
// Bench for goertzel_multibin with BLOCK_N=4, BINS=4, POWER_SHIFT=0: table of hand-computed
// blocks checked through a result scoreboard, plus stall, overrun and reset sequences.
module tb_goertzel_multibin;
    localparam int BINS = 4;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               coef_we;
    logic [1:0]         coef_addr;
    logic signed [17:0] coef_data;
    logic               sample_valid;
    logic signed [15:0] sample;
    logic               power_valid;
    logic               power_ready;
    logic [1:0]         power_bin;
    logic [63:0]        power;
    logic               power_last;
    logic               sample_overrun;
    logic               result_overrun;
`ifdef GOERTZEL_SAT_EN
    logic               satFlag;
`endif

    typedef struct packed {
        logic [1:0]  bin;
        logic [63:0] pwr;
        logic        last;
    } exp_t;

    typedef struct packed {
        logic [3:0][15:0] smp;
        logic [3:0][63:0] pwr;
    } vec_t;

    exp_t expQ[$];
    vec_t vecs[5];
    int   checks  = 0;
    int   errors  = 0;
    int   hsCount = 0;
    int   hs0;

    goertzel_multibin #(
        .BINS(BINS), .BLOCK_N(4), .POWER_SHIFT(0)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .sample_valid(sample_valid), .sample(sample),
        .power_valid(power_valid), .power_ready(power_ready),
        .power_bin(power_bin), .power(power), .power_last(power_last),
        .sample_overrun(sample_overrun), .result_overrun(result_overrun)
`ifdef GOERTZEL_SAT_EN
        , .sat_flag(satFlag)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Scoreboard consumer: every accepted result is matched against the oldest expectation.
    always @(negedge clock) begin
        exp_t e;
        if (reset_n === 1'b1 && power_valid === 1'b1 && power_ready === 1'b1) begin
            hsCount++;
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_result: got bin %0d power %0d, expected none", power_bin, power);
            end else begin
                e = expQ.pop_front();
                checkOutput($sformatf("result_bin%0d", e.bin), {power_bin, power, power_last}, {e.bin, e.pwr, e.last});
            end
        end
    end

    task automatic setVec(input int idx, input int s0, input int s1, input int s2, input int s3,
                          input longint p0, input longint p1, input longint p2, input longint p3);
        vecs[idx].smp[0] = 16'(s0);
        vecs[idx].smp[1] = 16'(s1);
        vecs[idx].smp[2] = 16'(s2);
        vecs[idx].smp[3] = 16'(s3);
        vecs[idx].pwr[0] = 64'(p0);
        vecs[idx].pwr[1] = 64'(p1);
        vecs[idx].pwr[2] = 64'(p2);
        vecs[idx].pwr[3] = 64'(p3);
    endtask

    task automatic applyStimulus(input logic signed [15:0] x);
        @(posedge clock); #1;
        sample_valid = 1'b1;
        sample       = x;
        @(posedge clock); #1;
        sample_valid = 1'b0;
        repeat (BINS) @(posedge clock);
    endtask

    task automatic writeCoef(input logic [1:0] addr, input logic signed [17:0] data);
        @(posedge clock); #1;
        coef_we   = 1'b1;
        coef_addr = addr;
        coef_data = data;
        @(posedge clock); #1;
        coef_we   = 1'b0;
    endtask

    task automatic pushVector(input vec_t v);
        for (int b = 0; b < BINS; b++)
            expQ.push_back('{bin: 2'(b), pwr: v.pwr[b], last: (b == BINS - 1)});
    endtask

    task automatic runVector(input vec_t v, input bit push);
        if (push) pushVector(v);
        for (int i = 0; i < 4; i++) applyStimulus(v.smp[i]);
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while ((expQ.size() != 0 || power_valid !== 1'b0) && n < 200) begin
            @(posedge clock); #2;
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("[TB] FAIL %s_drain: got %0d results pending, expected 0", name, expQ.size());
        end
    endtask

    task automatic waitValid(input string name);
        int n = 0;
        while (power_valid !== 1'b1 && n < 100) begin
            @(posedge clock); #2;
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("[TB] FAIL %s: got power_valid 0, expected 1", name);
        end
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_valid"}, power_valid, 0);
        checkOutput({name, "_power"}, power, 0);
        checkOutput({name, "_bin"}, power_bin, 0);
        checkOutput({name, "_last"}, power_last, 0);
        checkOutput({name, "_sovr"}, sample_overrun, 0);
        checkOutput({name, "_rovr"}, result_overrun, 0);
    endtask

    initial begin
        reset_n      = 1'b0;
        coef_we      = 1'b0;
        coef_addr    = '0;
        coef_data    = '0;
        sample_valid = 1'b0;
        sample       = '0;
        power_ready  = 1'b1;

        // Coefficients: bins 0,2,3 = 0.0, bin 1 = -2.0; powers worked out by hand.
        setVec(0, 1,  0, -1,  0, 4, 0,  4, 4);
        setVec(1, 1, -1,  1, -1, 0, 16, 0, 0);
        setVec(2, 3,  0,  0,  0, 9, 9,  9, 9);
        setVec(3, 2,  2,  2,  2, 0, 0,  0, 0);
        setVec(4, 1, -1,  1, -1, 0, 0,  0, 0);

        repeat (3) @(posedge clock); #1;
        checkResetOutputs("reset_init");
        reset_n = 1'b1;
        writeCoef(2'd1, 18'sh20000);

        for (int i = 0; i < 4; i++) begin
            runVector(vecs[i], 1'b1);
            waitDrain($sformatf("vec%0d", i));
        end

        // Backpressure: results must hold steady while ready is low.
        power_ready = 1'b0;
        runVector(vecs[0], 1'b1);
        waitValid("stall_valid");
        for (int c = 0; c < 20; c++) begin
            @(posedge clock); #2;
            checkOutput("stall_hold", {power_valid, power_bin, power, power_last},
                        {1'b1, expQ[0].bin, expQ[0].pwr, expQ[0].last});
        end
        hs0 = hsCount;
        power_ready = 1'b1;
        waitDrain("stall");
        repeat (10) @(posedge clock); #2;
        checkOutput("stall_handshakes", hsCount - hs0, 4);
        checkOutput("stall_valid_low", power_valid, 0);

        // Second sample two cycles after the first is dropped and must not count.
        checkOutput("sovr_clear", sample_overrun, 0);
        pushVector(vecs[0]);
        @(posedge clock); #1; sample_valid = 1'b1; sample = 16'sd1;
        @(posedge clock); #1; sample_valid = 1'b0;
        @(posedge clock); #1; sample_valid = 1'b1; sample = 16'sd5;
        @(posedge clock); #1; sample_valid = 1'b0;
        repeat (BINS) @(posedge clock);
        applyStimulus(16'sd0);
        applyStimulus(-16'sd1);
        applyStimulus(16'sd0);
        @(posedge clock); #2;
        checkOutput("sovr_set", sample_overrun, 1);
        waitDrain("sovr");

        // Two blocks complete with ready low: second is discarded, first survives.
        checkOutput("rovr_clear", result_overrun, 0);
        power_ready = 1'b0;
        runVector(vecs[1], 1'b1);
        runVector(vecs[2], 1'b0);
        @(posedge clock); #2;
        checkOutput("rovr_set", result_overrun, 1);
        checkOutput("rovr_head", {power_valid, power_bin, power, power_last},
                    {1'b1, expQ[0].bin, expQ[0].pwr, expQ[0].last});
        hs0 = hsCount;
        power_ready = 1'b1;
        waitDrain("rovr");
        repeat (10) @(posedge clock); #2;
        checkOutput("rovr_handshakes", hsCount - hs0, 4);

        // Reset in the middle of a sample update clears flags and coefficient RAM.
        @(posedge clock); #1; sample_valid = 1'b1; sample = 16'sd7;
        @(posedge clock); #1; sample_valid = 1'b0;
        @(posedge clock); #1; reset_n = 1'b0;
        #1 checkResetOutputs("reset_update");
        repeat (2) @(posedge clock); #1;
        reset_n = 1'b1;
        runVector(vecs[4], 1'b1);
        waitDrain("zero_coef");

        // Reset while a result is being presented drops it immediately.
        writeCoef(2'd1, 18'sh20000);
        power_ready = 1'b0;
        runVector(vecs[2], 1'b1);
        waitValid("present_valid");
        @(posedge clock); #1; reset_n = 1'b0;
        #1 checkResetOutputs("reset_present");
        expQ.delete();
        power_ready = 1'b1;
        repeat (2) @(posedge clock); #1;
        reset_n = 1'b1;
        writeCoef(2'd1, 18'sh20000);
        runVector(vecs[0], 1'b1);
        waitDrain("post_reset");
        repeat (10) @(posedge clock); #2;
        checkOutput("post_reset_idle", power_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
